// File: rtl/counter_event_monitor_if.sv
// Host-side observation bundle for the counter event monitor.
// The master drives the sampled host signals and reads the status outputs.
// The slave is the monitor itself.
interface counter_event_monitor_if #(
  parameter int VALUE_WIDTH   = 16,
  parameter int EVT_CNT_WIDTH = 8
);
  logic                     monitor_enable;
  logic                     clear;
  logic [VALUE_WIDTH-1:0]   counter_value;
  logic                     counter_overflow;
  logic                     counter_underflow;
  logic                     load_enable;
  logic [EVT_CNT_WIDTH-1:0] overflow_count;
  logic [EVT_CNT_WIDTH-1:0] underflow_count;
  logic [EVT_CNT_WIDTH-1:0] anomaly_count;
  logic                     anomaly_pulse;
  logic [2:0]               anomaly_code;
  logic [VALUE_WIDTH-1:0]   first_anomaly_value;
  logic                     alarm;

  modport master (
    output monitor_enable, clear, counter_value, counter_overflow,
           counter_underflow, load_enable,
    input  overflow_count, underflow_count, anomaly_count, anomaly_pulse,
           anomaly_code, first_anomaly_value, alarm
  );

  modport slave (
    input  monitor_enable, clear, counter_value, counter_overflow,
           counter_underflow, load_enable,
    output overflow_count, underflow_count, anomaly_count, anomaly_pulse,
           anomaly_code, first_anomaly_value, alarm
  );
endinterface

// File: rtl/counter_event_monitor.sv
// Consumer-side checker for the up/down counter host interface.
// Validates each cycle-to-cycle value transition, counts legal wraps and
// records anomalies; escalates to ALARM once enough anomalies pile up.
module counter_event_monitor #(
  parameter int VALUE_WIDTH     = 16,
  parameter int EVT_CNT_WIDTH   = 8,
  parameter int ALARM_THRESHOLD = 4,
  parameter int LOAD_WINDOW     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  counter_event_monitor_if.slave  mon
);

  localparam int TW = (LOAD_WINDOW < 1) ? 1 : $clog2(LOAD_WINDOW + 1);
  localparam logic [VALUE_WIDTH-1:0]   V_MAX     = '1;
  localparam logic [VALUE_WIDTH-1:0]   V_ZERO    = '0;
  localparam logic [VALUE_WIDTH-1:0]   V_ONE     = VALUE_WIDTH'(1);
  localparam logic [EVT_CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [EVT_CNT_WIDTH-1:0] CNT_ZERO  = '0;
  localparam logic [EVT_CNT_WIDTH-1:0] THRESH    = EVT_CNT_WIDTH'(ALARM_THRESHOLD);
  localparam logic [TW-1:0]            LOAD_INIT = TW'(LOAD_WINDOW);
  localparam logic [TW-1:0]            TMR_ZERO  = '0;
  localparam logic [TW-1:0]            TMR_ONE   = TW'(1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_PRIME    = 2'd1,
    ST_CHECK    = 2'd2,
    ST_ALARM    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [VALUE_WIDTH-1:0]   prev_q, prev_d;
  logic                     ovf_pend_q, unf_pend_q;
  logic [TW-1:0]            load_timer_q, load_timer_d;
  logic [EVT_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [EVT_CNT_WIDTH-1:0] unf_cnt_q, unf_cnt_d;
  logic [EVT_CNT_WIDTH-1:0] anom_cnt_q, anom_cnt_d;
  logic                     pulse_q, pulse_d;
  logic [2:0]               code_q, code_d;
  logic [VALUE_WIDTH-1:0]   first_q, first_d;
  logic                     alarm_q, alarm_d;

  logic                     check_active_s;
  logic                     wrap_ovf_s, wrap_unf_s;
  logic [2:0]               code_s;
  logic                     anomaly_s;
  logic [EVT_CNT_WIDTH-1:0] anom_inc_s;
  logic                     alarm_hit_s;

  function automatic logic [EVT_CNT_WIDTH-1:0] sat_inc(input logic [EVT_CNT_WIDTH-1:0] c);
    if (c == CNT_MAX) begin
      sat_inc = c;
    end else begin
      sat_inc = c + EVT_CNT_WIDTH'(1);
    end
  endfunction

  // Classify the current sample against the previous one, in priority order.
  always_comb begin
    logic p_max, p_zero, v_max, v_zero, step_ok;
    p_max   = (prev_q == V_MAX);
    p_zero  = (prev_q == V_ZERO);
    v_max   = (mon.counter_value == V_MAX);
    v_zero  = (mon.counter_value == V_ZERO);
    step_ok = (mon.counter_value == prev_q) ||
              (mon.counter_value == prev_q + V_ONE) ||
              (mon.counter_value == prev_q - V_ONE);
    wrap_ovf_s = ovf_pend_q && p_max && v_zero;
    wrap_unf_s = unf_pend_q && p_zero && v_max;
    if (mon.counter_overflow && mon.counter_underflow) begin
      code_s = 3'd6;
    end else if (ovf_pend_q && !(p_max && v_zero)) begin
      code_s = 3'd3;
    end else if (unf_pend_q && !(p_zero && v_max)) begin
      code_s = 3'd4;
    end else if (p_max && v_zero && !ovf_pend_q) begin
      code_s = 3'd1;
    end else if (p_zero && v_max && !unf_pend_q) begin
      code_s = 3'd2;
    end else if (!step_ok && !wrap_ovf_s && !wrap_unf_s && (load_timer_q == TMR_ZERO)) begin
      code_s = 3'd5;
    end else begin
      code_s = 3'd0;
    end
    check_active_s = mon.monitor_enable && ((state_q == ST_CHECK) || (state_q == ST_ALARM));
    anomaly_s      = check_active_s && (code_s != 3'd0);
    anom_inc_s     = sat_inc(anom_cnt_q);
    alarm_hit_s    = anomaly_s && !mon.clear && (anom_inc_s >= THRESH);
  end

  // Next state of the arming/alarm FSM and the registered alarm flag.
  always_comb begin
    state_d = state_q;
    if (!mon.monitor_enable) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED: state_d = ST_PRIME;
        ST_PRIME:    state_d = ST_CHECK;
        ST_CHECK:    state_d = alarm_hit_s ? ST_ALARM : ST_CHECK;
        ST_ALARM:    state_d = mon.clear ? ST_CHECK : ST_ALARM;
        default:     state_d = ST_DISARMED;
      endcase
    end
    alarm_d = (state_d == ST_ALARM);
  end

  // Counter, status and history updates; clear wins over same-cycle events.
  always_comb begin
    ovf_cnt_d  = ovf_cnt_q;
    unf_cnt_d  = unf_cnt_q;
    anom_cnt_d = anom_cnt_q;
    code_d     = code_q;
    first_d    = first_q;
    pulse_d    = 1'b0;
    if (mon.clear) begin
      ovf_cnt_d  = CNT_ZERO;
      unf_cnt_d  = CNT_ZERO;
      anom_cnt_d = CNT_ZERO;
      code_d     = 3'd0;
      first_d    = V_ZERO;
    end else if (check_active_s) begin
      if (wrap_ovf_s) begin
        ovf_cnt_d = sat_inc(ovf_cnt_q);
      end else begin
        ovf_cnt_d = ovf_cnt_q;
      end
      if (wrap_unf_s) begin
        unf_cnt_d = sat_inc(unf_cnt_q);
      end else begin
        unf_cnt_d = unf_cnt_q;
      end
      if (anomaly_s) begin
        pulse_d    = 1'b1;
        code_d     = code_s;
        anom_cnt_d = anom_inc_s;
        if (anom_cnt_q == CNT_ZERO) begin
          first_d = mon.counter_value;
        end else begin
          first_d = first_q;
        end
      end else begin
        pulse_d = 1'b0;
      end
    end else begin
      pulse_d = 1'b0;
    end
    if (state_q != ST_DISARMED) begin
      prev_d = mon.counter_value;
    end else begin
      prev_d = prev_q;
    end
    if (mon.load_enable) begin
      load_timer_d = LOAD_INIT;
    end else if (load_timer_q != TMR_ZERO) begin
      load_timer_d = load_timer_q - TMR_ONE;
    end else begin
      load_timer_d = TMR_ZERO;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DISARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= V_ZERO;
      ovf_pend_q   <= 1'b0;
      unf_pend_q   <= 1'b0;
      load_timer_q <= TMR_ZERO;
      ovf_cnt_q    <= CNT_ZERO;
      unf_cnt_q    <= CNT_ZERO;
      anom_cnt_q   <= CNT_ZERO;
      pulse_q      <= 1'b0;
      code_q       <= 3'd0;
      first_q      <= V_ZERO;
      alarm_q      <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      ovf_pend_q   <= mon.counter_overflow;
      unf_pend_q   <= mon.counter_underflow;
      load_timer_q <= load_timer_d;
      ovf_cnt_q    <= ovf_cnt_d;
      unf_cnt_q    <= unf_cnt_d;
      anom_cnt_q   <= anom_cnt_d;
      pulse_q      <= pulse_d;
      code_q       <= code_d;
      first_q      <= first_d;
      alarm_q      <= alarm_d;
    end
  end

  assign mon.overflow_count      = ovf_cnt_q;
  assign mon.underflow_count     = unf_cnt_q;
  assign mon.anomaly_count       = anom_cnt_q;
  assign mon.anomaly_pulse       = pulse_q;
  assign mon.anomaly_code        = code_q;
  assign mon.first_anomaly_value = first_q;
  assign mon.alarm               = alarm_q;

endmodule

// File: tb/tb_counter_event_monitor.sv
// Self-checking bench for counter_event_monitor: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_counter_event_monitor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  counter_event_monitor_if #(.VALUE_WIDTH(16), .EVT_CNT_WIDTH(8)) mon_if ();

  counter_event_monitor #(
    .VALUE_WIDTH(16), .EVT_CNT_WIDTH(8), .ALARM_THRESHOLD(4), .LOAD_WINDOW(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon_if)
  );

  logic [44:0] dut_vec;
  assign dut_vec = {mon_if.overflow_count, mon_if.underflow_count, mon_if.anomaly_count,
                    mon_if.anomaly_pulse, mon_if.anomaly_code, mon_if.first_anomaly_value,
                    mon_if.alarm};

  int n_cmp = 0;
  int n_bad = 0;
  int cur_v = 0;
  bit en_s  = 1'b0;

  // Behavioural model: plain integers following the monitor's rules.
  int m_ovf, m_unf, m_anom, m_code, m_first, m_prev, m_timer;
  bit m_pulse, m_alarm, m_opend, m_upend, m_prime, m_run;

  function automatic void model_reset();
    m_ovf = 0; m_unf = 0; m_anom = 0; m_code = 0; m_first = 0; m_prev = 0; m_timer = 0;
    m_pulse = 0; m_alarm = 0; m_opend = 0; m_upend = 0; m_prime = 0; m_run = 0;
  endfunction

  function automatic logic [44:0] exp_vec();
    return {8'(m_ovf), 8'(m_unf), 8'(m_anom), m_pulse, 3'(m_code), 16'(m_first), m_alarm};
  endfunction

  function automatic void model_step(int v, bit en, bit clr, bit of, bit uf, bit ld);
    int p, code;
    bit wo, wu, near;
    p    = m_prev;
    wo   = m_opend && p == 65535 && v == 0;
    wu   = m_upend && p == 0 && v == 65535;
    near = (v == p) || (v == (p + 1) % 65536) || (v == (p + 65535) % 65536);
    if (of && uf)                                   code = 6;
    else if (m_opend && !(p == 65535 && v == 0))    code = 3;
    else if (m_upend && !(p == 0 && v == 65535))    code = 4;
    else if (p == 65535 && v == 0 && !m_opend)      code = 1;
    else if (p == 0 && v == 65535 && !m_upend)      code = 2;
    else if (!near && !wo && !wu && m_timer == 0)   code = 5;
    else                                            code = 0;
    m_pulse = 0;
    if (clr) begin
      m_ovf = 0; m_unf = 0; m_anom = 0; m_code = 0; m_first = 0; m_alarm = 0;
    end else if (en && m_run) begin
      if (wo && m_ovf < 255) m_ovf++;
      if (wu && m_unf < 255) m_unf++;
      if (code != 0) begin
        m_pulse = 1;
        m_code  = code;
        if (m_anom == 0) m_first = v;
        if (m_anom < 255) m_anom++;
        if (m_anom >= 4) m_alarm = 1;
      end
    end
    if (m_prime || m_run) m_prev = v;
    if (!en) begin
      m_prime = 0; m_run = 0; m_alarm = 0;
    end else if (m_prime) begin
      m_prime = 0; m_run = 1;
    end else if (!m_run) begin
      m_prime = 1;
    end
    m_opend = of;
    m_upend = uf;
    m_timer = ld ? 2 : (m_timer > 0 ? m_timer - 1 : 0);
  endfunction

  // One clock of stimulus; the model advances on the same edge.
  task automatic cyc(input int v, input bit of = 0, input bit uf = 0,
                     input bit ld = 0, input bit clr = 0);
    mon_if.monitor_enable    = en_s;
    mon_if.clear             = clr;
    mon_if.counter_value     = 16'(v);
    mon_if.counter_overflow  = of;
    mon_if.counter_underflow = uf;
    mon_if.load_enable       = ld;
    cur_v = v;
    @(posedge clk);
    model_step(v, en_s, clr, of, uf, ld);
    #1;
  endtask

  task automatic jump_to(input int target);
    cyc(cur_v, 0, 0, 1);
    cyc(target);
  endtask

  task automatic arm(input int v);
    en_s = 1'b1;
    cyc(v);
    cyc(v);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_s = 1'b0;
    mon_if.monitor_enable = 1'b0; mon_if.clear = 1'b0; mon_if.counter_value = 16'h0000;
    mon_if.counter_overflow = 1'b0; mon_if.counter_underflow = 1'b0; mon_if.load_enable = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec !== 45'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec, 45'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_steps();
    int seq [3] = '{6, 7, 6};
    arm(5);
    foreach (seq[i]) begin
      cyc(seq[i]);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL steps[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if ({mon_if.anomaly_pulse, mon_if.anomaly_count, mon_if.overflow_count} !== 17'd0) begin
      n_bad++; $display("FAIL steps_quiet: got pulse=%0b anom=%0d ovf=%0d want 0",
                        mon_if.anomaly_pulse, mon_if.anomaly_count, mon_if.overflow_count);
    end
  endtask

  task automatic test_overflow_wrap();
    jump_to('hFFFE);
    cyc('hFFFF, 1, 0);
    cyc(0);
    n_cmp++;
    if (mon_if.overflow_count !== 8'd1 || mon_if.anomaly_pulse !== 1'b0) begin
      n_bad++; $display("FAIL overflow_wrap: got ovf=%0d pulse=%0b want ovf=1 pulse=0",
                        mon_if.overflow_count, mon_if.anomaly_pulse);
    end
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL overflow_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_underflow_saturate();
    for (int i = 0; i < 300; i++) begin
      cyc(0, 0, 1);
      cyc('hFFFF);
      if (i == 0) begin
        n_cmp++;
        if (mon_if.underflow_count !== 8'd1) begin
          n_bad++; $display("FAIL underflow_first: got %0d want 1", mon_if.underflow_count);
        end
      end
      cyc('hFFFE, 0, 0, 1);
      cyc(1);
    end
    n_cmp++;
    if (mon_if.underflow_count !== 8'hFF || mon_if.anomaly_count !== 8'd0) begin
      n_bad++; $display("FAIL underflow_saturate: got unf=%0d anom=%0d want unf=255 anom=0",
                        mon_if.underflow_count, mon_if.anomaly_count);
    end
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL underflow_model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_forced_zero();
    cyc(cur_v, 0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc('h1234, 0, 1);
    cyc(0);
    n_cmp++;
    if ({mon_if.anomaly_pulse, mon_if.anomaly_code, mon_if.first_anomaly_value,
         mon_if.anomaly_count} !== {1'b1, 3'd4, 16'h0000, 8'd1}) begin
      n_bad++; $display("FAIL forced_zero: got pulse=%0b code=%0d first=%h cnt=%0d want 1/4/0000/1",
                        mon_if.anomaly_pulse, mon_if.anomaly_code,
                        mon_if.first_anomaly_value, mon_if.anomaly_count);
    end
    cyc(0);
    n_cmp++;
    if (mon_if.anomaly_pulse !== 1'b0 || dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL forced_zero_strobe: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_load_window();
    cyc(cur_v, 0, 0, 0, 1);
    jump_to('h0010);
    cyc('h0010);
    cyc('h0010);
    cyc('h0010, 0, 0, 1);
    cyc('hA5A5);
    n_cmp++;
    if (mon_if.anomaly_pulse !== 1'b0 || mon_if.anomaly_count !== 8'd0) begin
      n_bad++; $display("FAIL load_excused: got pulse=%0b cnt=%0d want 0/0",
                        mon_if.anomaly_pulse, mon_if.anomaly_count);
    end
    cyc('hA5A5, 0, 0, 1);
    cyc('hA5A6);
    cyc('h5000);
    n_cmp++;
    if (mon_if.anomaly_pulse !== 1'b0 || dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL load_second_cycle: got %h want %h", dut_vec, exp_vec());
    end
    cyc('h5000);
    cyc('h0010);
    n_cmp++;
    if (mon_if.anomaly_pulse !== 1'b1 || mon_if.anomaly_code !== 3'd5) begin
      n_bad++; $display("FAIL unexcused_jump: got pulse=%0b code=%0d want 1/5",
                        mon_if.anomaly_pulse, mon_if.anomaly_code);
    end
  endtask

  task automatic test_alarm_clear_rst();
    int jumps [4] = '{'h0100, 'h8000, 'h0100, 'h8000};
    cyc(cur_v, 0, 0, 0, 1);
    cyc(cur_v);
    cyc(cur_v);
    foreach (jumps[i]) begin
      cyc(jumps[i]);
      n_cmp++;
      if (mon_if.alarm !== (i == 3) || dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL alarm_jump[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    cyc(cur_v, 0, 0, 0, 1);
    n_cmp++;
    if ({mon_if.alarm, mon_if.anomaly_count, mon_if.overflow_count, mon_if.underflow_count}
        !== 25'd0) begin
      n_bad++; $display("FAIL alarm_clear: got alarm=%0b anom=%0d want 0/0",
                        mon_if.alarm, mon_if.anomaly_count);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(jumps[i % 4]);
    end
    n_cmp++;
    if (mon_if.alarm !== 1'b1 || mon_if.anomaly_count !== 8'd6 || dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL alarm_hold: got %h want %h", dut_vec, exp_vec());
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dut_vec !== 45'd0) begin
      n_bad++; $display("FAIL rst_mid_alarm: got %h want %h", dut_vec, 45'd0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit of, uf, ld, clr;
    int v, r;
    arm(cur_v);
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 99));
      if (m_opend && cur_v == 'hFFFF && r < 70)      v = 0;
      else if (m_upend && cur_v == 0 && r < 70)      v = 'hFFFF;
      else if (r < 50) v = (cur_v + int'($urandom_range(0, 2)) + 65535) % 65536;
      else if (r < 65) v = ($urandom_range(0, 1) != 0) ? 'hFFFF : 0;
      else if (r < 75) v = int'($urandom_range(0, 65535));
      else             v = cur_v;
      of  = (v == 'hFFFF) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 49) == 0);
      uf  = (v == 0)      ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 49) == 0);
      ld  = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 49) == 0);
      en_s = ($urandom_range(0, 99) != 0);
      cyc(v, of, uf, ld, clr);
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_steps();
    test_overflow_wrap();
    test_underflow_saturate();
    test_forced_zero();
    test_load_window();
    test_alarm_clear_rst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
